// File: rtl/svf_pwm_out_if.sv
// Signal bundle between the state-variable filter and its PWM output stage.
// Master drives filter samples and controls; slave returns the gained sample and PWM.
interface svf_pwm_out_if #(
  parameter int W = 12
);
  logic signed [W-1:0] yl;
  logic signed [W-1:0] yb;
  logic signed [W-1:0] yh;
  logic signed [W-1:0] yn;
  logic [1:0]          mode;
  logic [7:0]          gain;
  logic                enable;
  logic                sample_tick;
  logic signed [W-1:0] sample_out;
  logic                pwm_out;
  logic                period_done;

  modport master (
    output yl, yb, yh, yn, mode, gain, enable, sample_tick,
    input  sample_out, pwm_out, period_done
  );

  modport slave (
    input  yl, yb, yh, yn, mode, gain, enable, sample_tick,
    output sample_out, pwm_out, period_done
  );
endinterface

// File: rtl/svf_pwm_out.sv
// SVF output stage: per-tick response select, U1.7 gain with saturation, then a
// single-bit PWM DAC whose duty only changes at period boundaries (glitch-free).
module svf_pwm_out #(
  parameter int W        = 12,
  parameter int PWM_BITS = 10
) (
  input  logic         clk,
  input  logic         rst,
  svf_pwm_out_if.slave bus
);
  localparam int PW = W + 9;
  localparam logic signed [PW-1:0] SAT_MAX = PW'((64'sd1 <<< (W - 1)) - 64'sd1);
  localparam logic signed [PW-1:0] SAT_MIN = ~SAT_MAX;
  localparam logic [PWM_BITS-1:0]  DUTY_MID = {1'b1, {(PWM_BITS-1){1'b0}}};
  localparam logic [W-1:0]         BIAS = {1'b1, {(W-1){1'b0}}};

  logic signed [W-1:0]  r_sample;
  logic [PWM_BITS-1:0]  r_cnt;
  logic [PWM_BITS-1:0]  r_duty;
  logic                 r_pwm;

  logic signed [W-1:0]  w_src;
  logic signed [PW-1:0] w_src_x;
  logic signed [PW-1:0] w_gain_x;
  logic signed [PW-1:0] w_prod;
  logic signed [PW-1:0] w_scaled;
  logic signed [W-1:0]  w_sat;
  logic [W-1:0]         w_biased;
  logic [PWM_BITS-1:0]  w_pend;
  logic                 w_at_max;

  always_comb begin
    w_src = bus.yl;
    case (bus.mode)
      2'd0: w_src = bus.yl;
      2'd1: w_src = bus.yb;
      2'd2: w_src = bus.yh;
      2'd3: w_src = bus.yn;
      default: w_src = bus.yl;
    endcase
  end

  // Gain is unsigned, so zero-extend it before the signed multiply.
  assign w_src_x  = PW'(w_src);
  assign w_gain_x = $signed({{(PW-8){1'b0}}, bus.gain});
  assign w_prod   = w_src_x * w_gain_x;
  assign w_scaled = w_prod >>> 7;

  always_comb begin
    w_sat = w_scaled[W-1:0];
    if (w_scaled > SAT_MAX)
      w_sat = SAT_MAX[W-1:0];
    else if (w_scaled < SAT_MIN)
      w_sat = SAT_MIN[W-1:0];
  end

  // Offset-binary view of the held sample; its top bits are the duty.
  assign w_biased = r_sample ^ BIAS;
  assign w_pend   = bus.enable ? PWM_BITS'(w_biased >> (W - PWM_BITS)) : DUTY_MID;
  assign w_at_max = &r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sample <= '0;
      r_cnt    <= '0;
      r_duty   <= DUTY_MID;
      r_pwm    <= 1'b0;
    end else begin
      if (bus.sample_tick)
        r_sample <= w_sat;
      r_cnt <= r_cnt + 1'b1;
      if (w_at_max)
        r_duty <= w_pend;
      r_pwm <= (r_cnt < r_duty);
    end
  end

  assign bus.sample_out  = r_sample;
  assign bus.pwm_out     = r_pwm;
  assign bus.period_done = w_at_max;
endmodule

// File: tb/tb_svf_pwm_out.sv
// Directed bench for svf_pwm_out: capture/gain/saturation, mute, boundary race, reset.
module tb_svf_pwm_out;
  logic clk = 1'b0;
  logic rst;
  int total = 0;
  int bad = 0;

  svf_pwm_out_if #(.W(12)) bus();
  svf_pwm_out #(.W(12), .PWM_BITS(10)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic drive_tick(input logic [1:0] m, input logic [7:0] g,
                            input logic signed [11:0] l, input logic signed [11:0] b,
                            input logic signed [11:0] h, input logic signed [11:0] n);
    @(negedge clk);
    bus.mode = m; bus.gain = g;
    bus.yl = l; bus.yb = b; bus.yh = h; bus.yn = n;
    bus.sample_tick = 1'b1;
    @(negedge clk);
    bus.sample_tick = 1'b0;
  endtask

  // Entered during a cnt=0 cycle; samples the 1024 pwm_out values of that period.
  task automatic count_window(output int hi, output int pd, output int pd_idx);
    hi = 0; pd = 0; pd_idx = -1;
    @(posedge clk);
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      if (bus.pwm_out === 1'b1) hi++;
      if (bus.period_done === 1'b1) begin
        pd++;
        if (pd_idx < 0) pd_idx = i;
      end
      @(posedge clk);
    end
  endtask

  task automatic measure_period(output int hi, output int pd, output bit found);
    int idx;
    found = 1'b0; hi = -1; pd = -1;
    for (int k = 0; k < 2100; k++) begin
      @(negedge clk);
      if (bus.period_done === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    if (found) begin
      @(posedge clk);
      count_window(hi, pd, idx);
    end
  endtask

  task automatic test_reset;
    int hi, pd, idx;
    rst = 1'b1;
    bus.yl = '0; bus.yb = '0; bus.yh = '0; bus.yn = '0;
    bus.mode = 2'd0; bus.gain = 8'h80; bus.enable = 1'b1; bus.sample_tick = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (bus.sample_out !== 12'sd0) begin bad++; $display("FAIL reset_sample got=%0d want=0", bus.sample_out); end
    total++; if (bus.pwm_out !== 1'b0) begin bad++; $display("FAIL reset_pwm got=%0b want=0", bus.pwm_out); end
    total++; if (bus.period_done !== 1'b0) begin bad++; $display("FAIL reset_pd got=%0b want=0", bus.period_done); end
    rst = 1'b0;
    count_window(hi, pd, idx);
    total++; if (hi != 512) begin bad++; $display("FAIL reset_duty got=%0d want=512", hi); end
    total++; if (idx != 1022) begin bad++; $display("FAIL reset_pd_pos got=%0d want=1022", idx); end
  endtask

  task automatic test_unity;
    int hi, pd; bit found;
    drive_tick(2'd0, 8'h80, 12'sd1024, 12'sd7, -12'sd7, 12'sd9);
    total++; if (bus.sample_out !== 12'sd1024) begin bad++; $display("FAIL unity_sample got=%0d want=1024", bus.sample_out); end
    measure_period(hi, pd, found);
    total++; if (!found) begin bad++; $display("FAIL unity_timeout got=0 want=1"); end
    total++; if (hi != 768) begin bad++; $display("FAIL unity_duty got=%0d want=768", hi); end
  endtask

  task automatic test_pos_sat;
    int hi, pd; bit found;
    drive_tick(2'd2, 8'hFF, 12'sd100, 12'sd0, 12'sd2047, 12'sd0);
    total++; if (bus.sample_out !== 12'sd2047) begin bad++; $display("FAIL possat_sample got=%0d want=2047", bus.sample_out); end
    measure_period(hi, pd, found);
    total++; if (!found) begin bad++; $display("FAIL possat_timeout got=0 want=1"); end
    total++; if (hi != 1023) begin bad++; $display("FAIL possat_duty got=%0d want=1023", hi); end
  endtask

  task automatic test_neg_sat;
    int hi, pd; bit found;
    drive_tick(2'd1, 8'hFF, 12'sd500, -12'sd2048, 12'sd0, 12'sd0);
    total++; if (bus.sample_out !== -12'sd2048) begin bad++; $display("FAIL negsat_sample got=%0d want=-2048", bus.sample_out); end
    measure_period(hi, pd, found);
    total++; if (!found) begin bad++; $display("FAIL negsat_timeout got=0 want=1"); end
    total++; if (hi != 0) begin bad++; $display("FAIL negsat_duty got=%0d want=0", hi); end
  endtask

  task automatic test_arith;
    // -3 * 0x40 = -192; arithmetic >>> 7 floors to -2.
    drive_tick(2'd0, 8'h40, -12'sd3, 12'sd0, 12'sd0, 12'sd0);
    total++; if (bus.sample_out !== -12'sd2) begin bad++; $display("FAIL floor_shift got=%0d want=-2", bus.sample_out); end
    drive_tick(2'd0, 8'h40, -12'sd300, 12'sd0, 12'sd0, 12'sd0);
    total++; if (bus.sample_out !== -12'sd150) begin bad++; $display("FAIL half_gain got=%0d want=-150", bus.sample_out); end
    drive_tick(2'd0, 8'h00, 12'sd1234, 12'sd0, 12'sd0, 12'sd0);
    total++; if (bus.sample_out !== 12'sd0) begin bad++; $display("FAIL zero_gain got=%0d want=0", bus.sample_out); end
    @(negedge clk);
    bus.mode = 2'd2; bus.gain = 8'hFF; bus.yh = 12'sd900;
    repeat (3) @(negedge clk);
    total++; if (bus.sample_out !== 12'sd0) begin bad++; $display("FAIL hold_no_tick got=%0d want=0", bus.sample_out); end
  endtask

  task automatic test_mute;
    int hi, pd; bit found;
    bus.enable = 1'b0;
    drive_tick(2'd3, 8'h80, 12'sd0, 12'sd0, 12'sd0, -12'sd1000);
    total++; if (bus.sample_out !== -12'sd1000) begin bad++; $display("FAIL mute_sample got=%0d want=-1000", bus.sample_out); end
    measure_period(hi, pd, found);
    total++; if (hi != 512) begin bad++; $display("FAIL mute_duty got=%0d want=512", hi); end
    bus.enable = 1'b1;
    measure_period(hi, pd, found);
    total++; if (hi != 262) begin bad++; $display("FAIL unmute_duty got=%0d want=262", hi); end
  endtask

  task automatic test_boundary_race;
    int hi, pd, idx; bit found;
    drive_tick(2'd0, 8'h80, 12'sd0, 12'sd0, 12'sd0, 12'sd0);
    measure_period(hi, pd, found);
    total++; if (hi != 512) begin bad++; $display("FAIL race_pre_duty got=%0d want=512", hi); end
    found = 1'b0;
    for (int k = 0; k < 2100; k++) begin
      @(negedge clk);
      if (bus.period_done === 1'b1) begin found = 1'b1; break; end
    end
    total++; if (!found) begin bad++; $display("FAIL race_timeout got=0 want=1"); end
    bus.yl = 12'sd1024; bus.gain = 8'h80; bus.mode = 2'd0; bus.sample_tick = 1'b1;
    @(negedge clk);
    bus.sample_tick = 1'b0;
    total++; if (bus.sample_out !== 12'sd1024) begin bad++; $display("FAIL race_sample got=%0d want=1024", bus.sample_out); end
    count_window(hi, pd, idx);
    total++; if (hi != 512) begin bad++; $display("FAIL race_old_duty got=%0d want=512", hi); end
    total++; if (pd != 1) begin bad++; $display("FAIL race_pd_count got=%0d want=1", pd); end
    measure_period(hi, pd, found);
    total++; if (hi != 768) begin bad++; $display("FAIL race_new_duty got=%0d want=768", hi); end
    total++; if (pd != 1) begin bad++; $display("FAIL race_pd_count2 got=%0d want=1", pd); end
  endtask

  task automatic test_reset_mid;
    int hi, pd, idx;
    // Leaves a cnt=1 cycle with duty 768 from the race test.
    repeat (299) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (bus.sample_out !== 12'sd0) begin bad++; $display("FAIL rstmid_sample got=%0d want=0", bus.sample_out); end
    total++; if (bus.pwm_out !== 1'b0) begin bad++; $display("FAIL rstmid_pwm got=%0b want=0", bus.pwm_out); end
    total++; if (bus.period_done !== 1'b0) begin bad++; $display("FAIL rstmid_pd got=%0b want=0", bus.period_done); end
    count_window(hi, pd, idx);
    total++; if (hi != 512) begin bad++; $display("FAIL rstmid_duty got=%0d want=512", hi); end
    total++; if (idx != 1022) begin bad++; $display("FAIL rstmid_cnt_restart got=%0d want=1022", idx); end
  endtask

  initial begin
    test_reset;
    test_unity;
    test_pos_sat;
    test_neg_sat;
    test_arith;
    test_mute;
    test_boundary_race;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/svf_pwm_out.md
# svf_pwm_out

Output stage directly downstream of the state-variable filter. Once per audio sample it selects one filter response (low-pass, band-pass, high-pass or notch), applies an 8-bit volume gain with saturation, and holds the result. It then drives a single-bit PWM DAC, whose duty cycle is updated only at PWM period boundaries so no pulse is ever glitched.

## Interface

**Parameters**
- `W`, 12: width of the signed filter outputs and of `sample_out`.
- `PWM_BITS`, 10: PWM counter width. Period = 2^PWM_BITS clk cycles. Must be ≤ W.

**Ports**
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `yl`, `yb`, `yh`, `yn`  in  W each  signed filter outputs (low/band/high/notch).
- `mode`  in  2  source select: 0=yl, 1=yb, 2=yh, 3=yn.
- `gain`  in  8  unsigned volume, U1.7 format; 0x80 = unity.
- `enable`  in  1  0 = mute (output held at midscale).
- `sample_tick`  in  1  one-cycle strobe marking the audio sample instant.
- `sample_out`  out  W  signed, gained, saturated sample (registered).
- `pwm_out`  out  1  registered PWM bit.
- `period_done`  out  1  one-cycle pulse on the last cycle of each PWM period.

## Operation

- **Capture.** On a cycle with `sample_tick`=1:
  - src = the input selected by `mode`.
  - prod = signed(src) × signed({1'b0, gain}), computed at full width (W+9 bits).
  - scaled = prod >>> 7 (arithmetic shift).
  - Saturate scaled to [−2^(W−1), 2^(W−1)−1] and register it into `sample_out`.
  - `mode` and `gain` are sampled only at the tick. Changes between ticks take effect at the next tick.
- **Hold.** Without a tick, `sample_out` holds its value.
- **Pending duty** (combinational):
  - `enable`=1: ((sample_out + 2^(W−1)) as unsigned W-bit) >> (W − PWM_BITS).
  - `enable`=0: 2^(PWM_BITS−1).
- **PWM counter.** `cnt`, PWM_BITS wide, free-running from 0 up to 2^PWM_BITS−1, then wraps to 0.
- **Duty update.** When `cnt` = max, `duty_active` loads the pending duty. The new duty therefore governs the period that starts at `cnt`=0. `duty_active` never changes at any other time.
- **Output.** `pwm_out` is registered as (cnt < duty_active).
  - duty 0: output low for the whole period.
  - duty max: output high for 2^PWM_BITS−1 of 2^PWM_BITS cycles.
- **Period pulse.** `period_done` = 1 exactly when `cnt` = max.

## Timing

**Reset values** (one clk after `rst` sampled high):
- `sample_out`=0, `cnt`=0, `duty_active`=2^(PWM_BITS−1), `pwm_out`=0, `period_done`=0.

**Reset mid-operation.** All state returns to the reset values on the next edge, regardless of tick or counter position. The counter restarts at 0.

**Latency**
- tick at cycle t → `sample_out` valid at t+1.
- That value reaches `duty_active` at the first `cnt`=max edge at or after t+1.
- `pwm_out` lags the (cnt, duty_active) comparison by 1 cycle.

**Boundary cases**
- Tick on the same cycle as `cnt`=max: `duty_active` loads the pending duty derived from the old `sample_out`. The new sample applies one period later.
- Back-to-back ticks: every tick captures. Only the last `sample_out` before a boundary is used.
- Several ticks within one PWM period: intermediate samples are dropped by design.
- `enable` falling mid-period: midscale takes effect at the next boundary. `sample_out` keeps tracking ticks.
- `gain`=0: `sample_out`=0.
- `yn` is taken as delivered. No re-saturation is applied before gain.

## Test plan

- **Unity gain.** mode=0, yl=0x400 (1024), gain=0x80, tick → `sample_out`=1024 at t+1. After the next boundary, `pwm_out` is high 768 of 1024 cycles.
- **Positive saturation.** mode=2, yh=2047, gain=0xFF, tick → 2047·255>>7 = 4078, saturated to `sample_out`=2047. Duty 1023, so `pwm_out` is high 1023 of 1024 cycles.
- **Negative saturation / source select.** mode=1, yb=−2048, gain=0xFF, tick → `sample_out`=−2048. Duty 0, so `pwm_out` is low for the entire period. A simultaneous yl=500 must not leak through.
- **Mute.** mode=3, yn=−1000, gain=0x80, `enable`=0 → `sample_out`=−1000, but duty is 512 (50%). Raise `enable` → duty becomes (−1000+2048)>>2 = 262 from the next period.
- **Boundary race.** Previous sample=0. Tick with yl=1024 on the `cnt`=1023 cycle → the next period has duty 512, the following period has duty 768. `period_done` pulses exactly once per 1024 cycles.
- **Reset mid-period.** Assert `rst` at `cnt`=300 with duty 768 → next cycle `cnt`=0, `sample_out`=0, `duty_active`=512, `pwm_out`=0. The following period is 50%.
